button_event_arbiter: RTL and testbench
=======================================

Name: button_event_arbiter

Overview:
- Front-end controller for the alarm-clock push buttons: synchronises and debounces NUM_BTN raw button inputs.
- Generates press and hold-auto-repeat events per button.
- Round-robin arbitrates pending events onto one valid/ready event channel consumed by the mode/time-set FSM.
- Replaces ad-hoc per-button edge detectors with one scheduled event source.

Parameters:
- NUM_BTN, 4, number of buttons
- ID_W, 2, width of evt_id; must satisfy 2^ID_W >= NUM_BTN
- DEBOUNCE_CYCLES, 16, cycles a synchronised level must differ from the debounced level before it is accepted; must be >= 1
- HOLD_CYCLES, 64, cycles of debounced-high before the first repeat event
- REPEAT_CYCLES, 16, cycles between subsequent repeat events; must be <= HOLD_CYCLES
- CNT_W, 8, width of the per-button debounce and hold counters; must hold HOLD_CYCLES-1

Ports:
- clk, in, 1, single clock; all logic on posedge
- rst_n, in, 1, synchronous active-low reset
- btn_raw, in, NUM_BTN, asynchronous raw button levels, active high
- evt_valid, out, 1, an event is offered
- evt_ready, in, 1, consumer accepts the event
- evt_id, out, ID_W, index of the button that produced the event
- evt_repeat, out, 1, 0 = initial press, 1 = auto-repeat
- evt_drop, out, 1, one-cycle pulse: an event was discarded because that button already had one pending
- btn_level, out, NUM_BTN, debounced button levels

Behaviour:
- Reset: rst_n sampled low at posedge clears all synchroniser flops, counters, debounced levels, pending/type bits and the round-robin pointer (last = NUM_BTN-1, so button 0 has first priority). FSM goes to IDLE. All outputs are 0.
- Synchroniser: each button passes through a 2-flop chain, s1 then s2. No logic is placed between the two flops.
- Debounce, per button:
  - If s2 == db: cnt <= 0.
  - Else if cnt == DEBOUNCE_CYCLES-1: db <= s2, cnt <= 0.
  - Else: cnt <= cnt+1.
  - Any glitch back to the old level restarts the count.
  - btn_level = db.
- Press event: generated on the cycle after db rises 0->1; this is a registered edge compare of db against db_d. A release generates no event.
- Hold/repeat, per button:
  - hold_cnt clears while db = 0 and increments each cycle while db = 1.
  - When hold_cnt == HOLD_CYCLES-1: emit a repeat event and load hold_cnt <= HOLD_CYCLES-REPEAT_CYCLES.
  - Repeats therefore occur at HOLD_CYCLES, HOLD_CYCLES+REPEAT_CYCLES, and so on after the db rise.
- Pending, per button: the pend and rtype bits are set by an event.
  - If pend is already 1 and not being granted this cycle, the new event is discarded, evt_drop pulses for 1 cycle, and the existing pend/rtype are kept.
  - If a grant clears pend in the same cycle a new event sets it, the set wins (pend stays 1, rtype = new type) and no drop is flagged.
- Output FSM:
  - IDLE: if any pend = 1, select the first pending index searching from last+1 with wrap-around. Then register evt_id = idx, evt_repeat = rtype[idx], evt_valid <= 1; clear pend[idx]; last <= idx; go to OFFER.
  - OFFER: evt_valid, evt_id and evt_repeat are held stable until evt_valid & evt_ready at a posedge. Then evt_valid <= 0 and the FSM goes to IDLE. This gives a one-cycle bubble between events.
  - evt_ready is ignored in IDLE.
- Latency: with btn_raw rising just before posedge k and then stable, db = 1 after posedge k+1+DEBOUNCE_CYCLES and evt_valid = 1 after posedge k+3+DEBOUNCE_CYCLES. This holds when the FSM is IDLE and no other button is pending.
- Reset mid-operation: an offered event is discarded without handshake; all pending events are lost.

Test Plan:
- Bench parameters throughout: DEBOUNCE_CYCLES = 4, HOLD_CYCLES = 16, REPEAT_CYCLES = 4, evt_ready = 1 unless stated.
- Clean press of btn_raw[2], held 10 cycles then released:
  - evt_valid rises exactly 7 cycles after the first sampling edge, with evt_id = 2, evt_repeat = 0.
  - Exactly one event; no event on release.
- Bounce on btn_raw[0]: toggle every 2 cycles for 20 cycles, then stable low -> no event, btn_level[0] stays 0. Then stable high for 4+ cycles -> one press event with id 0.
- Hold btn_raw[1] high for 40 cycles -> press event at db rise plus 1, then repeat events (evt_repeat = 1, id = 1) at db rise plus 17, 21, 25, ... until release.
- Buttons 0, 1 and 3 press in the same cycle -> grants in order 0, 1, 3. Next simultaneous press of 0 and 3 (last = 3) -> order 0, 3.
- Hold evt_ready = 0 while button 1 is offered:
  - evt_id/evt_repeat stay stable.
  - A held button 1 producing a repeat becomes pending; a second repeat -> evt_drop pulses once.
  - Releasing evt_ready delivers the offered event, then the pending repeat.
- Assert rst_n = 0 for 1 cycle while in OFFER with pending events -> next cycle evt_valid = 0, btn_level = 0, evt_drop = 0, and no stale events are delivered afterwards.

Source files
------------

// File: rtl/button_event_arbiter.sv
// button_event_arbiter
//   Synchronises and debounces NUM_BTN raw push buttons, turns each debounced
//   press into a press event plus hold auto-repeat events, and round-robin
//   schedules the pending events onto a single valid/ready channel.
//
// Ports
//   clk        : single clock, all logic on posedge
//   rst_n      : synchronous active-low reset
//   btn_raw    : asynchronous raw button levels, active high
//   evt_valid  : an event is offered
//   evt_ready  : consumer accepts the offered event
//   evt_id     : index of the button that produced the offered event
//   evt_repeat : 0 = initial press, 1 = auto-repeat
//   evt_drop   : one-cycle pulse, an event hit a button that was still pending
//   btn_level  : debounced button levels
//
// Output FSM
//   state | meaning
//   IDLE  | nothing offered; grant the next pending button if any
//   OFFER | event registered on evt_*; hold it until evt_ready
module button_event_arbiter #(
  parameter int NUM_BTN         = 4,
  parameter int ID_W            = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int HOLD_CYCLES     = 64,
  parameter int REPEAT_CYCLES   = 16,
  parameter int CNT_W           = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic               evt_valid,
  input  logic               evt_ready,
  output logic [ID_W-1:0]    evt_id,
  output logic               evt_repeat,
  output logic               evt_drop,
  output logic [NUM_BTN-1:0] btn_level
);

  localparam logic [CNT_W-1:0] DB_LAST     = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_RELOAD = CNT_W'(HOLD_CYCLES - REPEAT_CYCLES);

  typedef enum logic {IDLE, OFFER} state_t;

  state_t             state;
  logic [NUM_BTN-1:0] s1, s2, db, dbD, repEvt;
  logic [CNT_W-1:0]   dbCnt   [NUM_BTN];
  logic [CNT_W-1:0]   holdCnt [NUM_BTN];
  logic [NUM_BTN-1:0] pend, rtype;
  logic [NUM_BTN-1:0] press, newEvt, dropVec, grant;
  logic [ID_W-1:0]    last, selIdx, cand;
  logic               anyPend, found;

  // Synchroniser, debounce and hold timers. repEvt is registered so a repeat
  // reaches the pending stage HOLD_CYCLES after the press does.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1     <= '0;
      s2     <= '0;
      db     <= '0;
      dbD    <= '0;
      repEvt <= '0;
      for (int i = 0; i < NUM_BTN; i++) begin
        dbCnt[i]   <= '0;
        holdCnt[i] <= '0;
      end
    end else begin
      s1  <= btn_raw;
      s2  <= s1;
      dbD <= db;
      for (int i = 0; i < NUM_BTN; i++) begin
        if (s2[i] == db[i]) begin
          dbCnt[i] <= '0;
        end else if (dbCnt[i] == DB_LAST) begin
          db[i]    <= s2[i];
          dbCnt[i] <= '0;
        end else begin
          dbCnt[i] <= dbCnt[i] + 1'b1;
        end

        repEvt[i] <= db[i] && (holdCnt[i] == HOLD_LAST);
        if (!db[i]) begin
          holdCnt[i] <= '0;
        end else if (holdCnt[i] == HOLD_LAST) begin
          holdCnt[i] <= HOLD_RELOAD;
        end else begin
          holdCnt[i] <= holdCnt[i] + 1'b1;
        end
      end
    end
  end

  assign press     = db & ~dbD;
  assign newEvt    = press | repEvt;
  assign dropVec   = newEvt & pend & ~grant;
  assign btn_level = db;
  assign anyPend   = |pend;

  // Round-robin pick: first pending index after last, wrapping around.
  always_comb begin
    selIdx = '0;
    cand   = '0;
    found  = 1'b0;
    for (int off = 1; off <= NUM_BTN; off++) begin
      cand = ID_W'((int'(last) + off) % NUM_BTN);
      if (!found && pend[cand]) begin
        selIdx = cand;
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    grant = '0;
    if (state == IDLE && anyPend) grant[selIdx] = 1'b1;
  end

  // A new event beats a same-cycle grant clear; it only drops when the
  // button is still pending and not being granted.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend     <= '0;
      rtype    <= '0;
      evt_drop <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_BTN; i++) begin
        if (newEvt[i] && !dropVec[i]) begin
          pend[i]  <= 1'b1;
          rtype[i] <= repEvt[i];
        end else if (grant[i]) begin
          pend[i] <= 1'b0;
        end
      end
      evt_drop <= |dropVec;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      evt_valid  <= 1'b0;
      evt_id     <= '0;
      evt_repeat <= 1'b0;
      last       <= ID_W'(NUM_BTN - 1);
    end else begin
      case (state)
        IDLE: begin
          if (anyPend) begin
            evt_id     <= selIdx;
            evt_repeat <= rtype[selIdx];
            evt_valid  <= 1'b1;
            last       <= selIdx;
            state      <= OFFER;
          end
        end
        OFFER: begin
          if (evt_ready) begin
            evt_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_button_event_arbiter.sv
module tb_button_event_arbiter;

  localparam int NB = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NB-1:0] btn_raw = '0;
  logic          evt_ready = 1'b1;
  logic          evt_valid;
  logic [1:0]    evt_id;
  logic          evt_repeat;
  logic          evt_drop;
  logic [NB-1:0] btn_level;

  button_event_arbiter #(
    .NUM_BTN(4), .ID_W(2), .DEBOUNCE_CYCLES(4),
    .HOLD_CYCLES(16), .REPEAT_CYCLES(4), .CNT_W(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .btn_raw(btn_raw),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_id(evt_id),
    .evt_repeat(evt_repeat), .evt_drop(evt_drop), .btn_level(btn_level)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int hsCyc[$];
  int hsId[$];
  int hsRep[$];
  int dropCnt = 0;

  // Handshake log: sampled just after the negedge, when inputs driven at the
  // negedge have settled and hold until the next posedge.
  always begin
    @(negedge clk);
    #1;
    if (rst_n) begin
      if (evt_valid && evt_ready) begin
        hsCyc.push_back(cyc);
        hsId.push_back(int'(evt_id));
        hsRep.push_back(int'(evt_repeat));
      end
      if (evt_drop) dropCnt++;
    end
  end

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clearLog();
    hsCyc.delete();
    hsId.delete();
    hsRep.delete();
    dropCnt = 0;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic waitUntil(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic waitValid(input int maxc, output int at);
    at = -1;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      if (evt_valid) begin
        at = cyc;
        break;
      end
    end
  endtask

  task automatic doReset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int k;
    int at;
    int bad;
    int unstable;

    repeat (3) @(negedge clk);
    checkVal("rst_valid", evt_valid, 0);
    checkVal("rst_id", evt_id, 0);
    checkVal("rst_repeat", evt_repeat, 0);
    checkVal("rst_drop", evt_drop, 0);
    checkVal("rst_level", btn_level, 0);
    rst_n = 1'b1;
    waitCycles(2);

    // Clean press of button 2, high for 10 sampling edges.
    clearLog();
    btn_raw[2] = 1'b1;
    k = cyc + 1;
    waitValid(20, at);
    checkVal("t1_latency", at, k + 7);
    checkVal("t1_id", evt_id, 2);
    checkVal("t1_repeat", evt_repeat, 0);
    waitUntil(k + 9);
    btn_raw[2] = 1'b0;
    waitCycles(20);
    checkVal("t1_count", hsCyc.size(), 1);
    checkVal("t1_level_after", btn_level, 0);

    // Bounce on button 0: 2 high / 2 low for 20 cycles, then low.
    clearLog();
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      btn_raw[0] = 1'b1;
      repeat (2) begin @(negedge clk); if (btn_level[0]) bad++; end
      btn_raw[0] = 1'b0;
      repeat (2) begin @(negedge clk); if (btn_level[0]) bad++; end
    end
    repeat (10) begin @(negedge clk); if (btn_level[0]) bad++; end
    checkVal("t2_bounce_level", bad, 0);
    checkVal("t2_bounce_events", hsCyc.size(), 0);
    btn_raw[0] = 1'b1;
    k = cyc + 1;
    waitValid(20, at);
    checkVal("t2_latency", at, k + 7);
    checkVal("t2_id", evt_id, 0);
    checkVal("t2_repeat", evt_repeat, 0);
    waitUntil(k + 9);
    btn_raw[0] = 1'b0;
    waitCycles(20);
    checkVal("t2_count", hsCyc.size(), 1);

    // Hold button 1 for 38 sampling edges: db high from k+5 to k+43, so
    // repeat offers land 16 after the press offer and then every 4 cycles,
    // six of them before the release.
    clearLog();
    btn_raw[1] = 1'b1;
    k = cyc + 1;
    waitUntil(k + 37);
    btn_raw[1] = 1'b0;
    waitCycles(25);
    checkVal("t3_count", hsCyc.size(), 7);
    if (hsCyc.size() == 7) begin
      checkVal("t3_press_cyc", hsCyc[0], k + 7);
      checkVal("t3_press_id", hsId[0], 1);
      checkVal("t3_press_rep", hsRep[0], 0);
      for (int i = 1; i < 7; i++) begin
        checkVal($sformatf("t3_rep%0d_gap", i), hsCyc[i] - hsCyc[i-1], (i == 1) ? 16 : 4);
        checkVal($sformatf("t3_rep%0d_id", i), hsId[i], 1);
        checkVal($sformatf("t3_rep%0d_rep", i), hsRep[i], 1);
      end
    end

    // Simultaneous presses after reset (last = 3): 0, 1, 3 then 0, 3.
    doReset();
    waitCycles(2);
    clearLog();
    btn_raw = 4'b1011;
    k = cyc + 1;
    waitUntil(k + 9);
    btn_raw = 4'b0000;
    waitCycles(20);
    checkVal("t4a_count", hsCyc.size(), 3);
    if (hsCyc.size() == 3) begin
      checkVal("t4a_first", hsId[0], 0);
      checkVal("t4a_second", hsId[1], 1);
      checkVal("t4a_third", hsId[2], 3);
    end
    clearLog();
    btn_raw = 4'b1001;
    k = cyc + 1;
    waitUntil(k + 9);
    btn_raw = 4'b0000;
    waitCycles(20);
    checkVal("t4b_count", hsCyc.size(), 2);
    if (hsCyc.size() == 2) begin
      checkVal("t4b_first", hsId[0], 0);
      checkVal("t4b_second", hsId[1], 3);
    end

    // Stall with evt_ready = 0 while button 1 is held: first repeat goes
    // pending, second one is dropped; release of raw before a third.
    clearLog();
    evt_ready = 1'b0;
    btn_raw[1] = 1'b1;
    k = cyc + 1;
    waitValid(20, at);
    checkVal("t5_latency", at, k + 7);
    unstable = 0;
    while (cyc < k + 35) begin
      if (cyc == k + 21) btn_raw[1] = 1'b0;
      @(negedge clk);
      if (!(evt_valid && evt_id == 2'd1 && !evt_repeat)) unstable++;
    end
    checkVal("t5_stable", unstable, 0);
    checkVal("t5_drops", dropCnt, 1);
    checkVal("t5_held_id", evt_id, 1);
    evt_ready = 1'b1;
    waitCycles(10);
    checkVal("t5_count", hsCyc.size(), 2);
    if (hsCyc.size() == 2) begin
      checkVal("t5_first_rep", hsRep[0], 0);
      checkVal("t5_second_id", hsId[1], 1);
      checkVal("t5_second_rep", hsRep[1], 1);
    end

    // Reset while offering with another button pending (last = 1 -> 2 first).
    clearLog();
    evt_ready = 1'b0;
    btn_raw = 4'b0101;
    waitValid(20, at);
    waitCycles(2);
    checkVal("t6_pre_valid", evt_valid, 1);
    checkVal("t6_pre_id", evt_id, 2);
    @(negedge clk);
    rst_n = 1'b0;
    btn_raw = 4'b0000;
    @(negedge clk);
    rst_n = 1'b1;
    checkVal("t6_valid", evt_valid, 0);
    checkVal("t6_level", btn_level, 0);
    checkVal("t6_drop", evt_drop, 0);
    evt_ready = 1'b1;
    waitCycles(30);
    checkVal("t6_stale", hsCyc.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
